// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default sample/coefficient and accumulator widths
  localparam int DEF_DW = 16;
  localparam int DEF_AW = 39;

  // Width of a tap index; never less than one bit
  function automatic int tap_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Single multiply-accumulate unit shared by all taps of the filter.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] prod;

  // Full-width unsigned product; operands widened so no bits are lost
  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  // Accumulator: clear wins over accumulate so a new sample always starts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: owns delay line and coefficient bank, runs one MAC per tap per sample.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AW-1:0]                out_data,
  input  logic                         coef_we,
  input  logic [tap_width(NTAPS)-1:0]  coef_addr,
  input  logic [DW-1:0]                coef_data,
  output logic                         busy
);

  localparam int KW = tap_width(NTAPS);

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [DW-1:0] d [NTAPS];
  logic [DW-1:0] c [NTAPS];
  logic [AW-1:0] acc;
  logic          accept;
  logic          mac_en;
  logic          last_tap;
  logic          coef_ok;

  assign accept   = (state == ST_IDLE) && in_valid;
  assign mac_en   = (state == ST_MAC);
  assign last_tap = (k == KW'(NTAPS - 1));
  assign coef_ok  = (state == ST_IDLE) && coef_we && (32'(coef_addr) < NTAPS);
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  fir_mac_unit #(
    .DW(DW),
    .AW(AW)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (mac_en),
    .a  (d[k]),
    .b  (c[k]),
    .acc(acc)
  );

  // Control FSM: accept a sample, step through every tap, then hold the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state <= ST_MAC;
            k     <= '0;
          end
        end
        ST_MAC: begin
          if (last_tap) begin
            state <= ST_DONE;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Delay line: newest sample enters at d[0]; history survives across samples
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) d[i] <= '0;
    end else if (accept) begin
      for (int i = NTAPS - 1; i > 0; i--) d[i] <= d[i-1];
      d[0] <= in_data;
    end
  end

  // Coefficient bank: writable only while idle so a running sum never sees a changing tap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) c[i] <= '0;
    end else if (coef_ok) begin
      c[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer against an arithmetic reference model.
module tb_fir_mac_sequencer;

  localparam int NTAPS = 8;
  localparam int DW    = 16;
  localparam int AW    = 39;
  localparam int KW    = $clog2(NTAPS);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          coef_we;
  logic [KW-1:0] coef_addr;
  logic [DW-1:0] coef_data;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  longint unsigned d_m [NTAPS];
  longint unsigned c_m [NTAPS];

  fir_mac_sequencer #(
    .NTAPS(NTAPS),
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  function automatic logic [63:0] modelOut();
    longint unsigned s;
    s = 0;
    for (int i = 0; i < NTAPS; i++) s += d_m[i] * c_m[i];
    return 64'(AW'(s));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NTAPS; i++) begin
      d_m[i] = 0;
      c_m[i] = 0;
    end
  endtask

  task automatic modelPush(input logic [DW-1:0] s);
    for (int i = NTAPS - 1; i > 0; i--) d_m[i] = d_m[i-1];
    d_m[0] = longint'(s);
  endtask

  task automatic writeCoef(input int addr, input logic [DW-1:0] val);
    coef_we   = 1'b1;
    coef_addr = KW'(addr);
    coef_data = val;
    tick();
    coef_we = 1'b0;
    c_m[addr] = longint'(val);
  endtask

  // Offer one sample and return once it has been accepted
  task automatic applyStimulus(input logic [DW-1:0] s);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = s;
    tick();
    in_valid = 1'b0;
    modelPush(s);
  endtask

  // Wait for a result, compare it, then complete the output handshake
  task automatic checkOutput(input string tag, input logic [63:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, 64'(out_data), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int acc_edge;
    int n;
    logic [63:0] held;
    logic [DW-1:0] s;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    modelReset();
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_busy", busy, 0);

    // Impulse response reproduces the coefficients in order
    for (int i = 0; i < NTAPS; i++) writeCoef(i, DW'(i + 1));
    for (int i = 0; i <= NTAPS; i++) begin
      applyStimulus((i == 0) ? DW'(1) : DW'(0));
      checkOutput("impulse", (i < NTAPS) ? 64'(i + 1) : 64'd0);
    end

    // Latency and return to idle
    in_valid = 1'b1;
    in_data  = DW'(3);
    tick();
    in_valid = 1'b0;
    modelPush(DW'(3));
    acc_edge = cyc;
    check("busy_in_mac", busy, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("latency", 64'(cyc - acc_edge), 64'(NTAPS + 1));
    check("latency_data", 64'(out_data), modelOut());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready_return", in_ready, 1);
    check("ready_return_edge", 64'(cyc - acc_edge), 64'(NTAPS + 2));

    // Random coefficients and samples
    for (int i = 0; i < NTAPS; i++) writeCoef(i, DW'($urandom));
    for (int i = 0; i < 6; i++) begin
      applyStimulus(DW'($urandom));
      checkOutput("random", modelOut());
    end

    // Maximum operands: accumulator must reach its largest value without wrapping
    for (int i = 0; i < NTAPS; i++) writeCoef(i, 16'hFFFF);
    for (int i = 0; i < NTAPS; i++) begin
      applyStimulus(16'hFFFF);
      if (i == NTAPS - 1) checkOutput("max_value", 64'h7_FFF0_0008);
      else checkOutput("max_ramp", modelOut());
    end

    // Backpressure with a pending input sample
    for (int i = 0; i < NTAPS; i++) writeCoef(i, DW'($urandom_range(1, 1000)));
    applyStimulus(DW'($urandom_range(1, 5000)));
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    held = modelOut();
    s = DW'($urandom_range(1, 5000));
    in_valid = 1'b1;
    in_data  = s;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", 64'(out_data), held);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_not_consumed", busy, 0);
    tick();
    in_valid = 1'b0;
    modelPush(s);
    check("bp_consumed", busy, 1);
    checkOutput("bp_next", modelOut());

    // Coefficient write during MAC is dropped; the same write while idle takes effect
    s = DW'($urandom_range(1, 5000));
    applyStimulus(s);
    tick();
    coef_we = 1'b1; coef_addr = '0; coef_data = DW'(100);
    tick();
    coef_we = 1'b0;
    checkOutput("busy_write_dropped", modelOut());
    writeCoef(0, DW'(100));
    applyStimulus(DW'($urandom_range(1, 5000)));
    checkOutput("idle_write_applied", modelOut());

    // Reset in the middle of a computation aborts it
    applyStimulus(DW'(77));
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    for (int i = 0; i < NTAPS + 4; i++) tick();
    check("abort_no_result", out_valid, 0);
    writeCoef(0, DW'(2));
    applyStimulus(DW'(5));
    checkOutput("after_abort", 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
